button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, is the number of consecutive identical synchronized samples needed to accept a level change (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 btn0_raw  input  1  asynchronous, bouncy push-button 0 (1 = pressed).
REQ-005 btn1_raw  input  1  asynchronous, bouncy push-button 1 (1 = pressed).
REQ-006 b0  output  1  registered one-cycle pulse, one per accepted press of button 0; drives the lock's b0 input.
REQ-007 b1  output  1  registered one-cycle pulse, one per accepted press of button 1; drives the lock's b1 input.
REQ-008 chord_err  output  1  registered one-cycle pulse, asserted when both buttons are held at once.

Function
REQ-009 Each raw input SHALL pass through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-010 Each channel SHALL hold a debounced level deb (reset 0) and a counter cnt of width ceil(log2(DEBOUNCE_CYCLES)).
REQ-011 If sync2 equals deb, cnt SHALL clear to 0.
REQ-012 If sync2 differs from deb and cnt < DEBOUNCE_CYCLES-1, cnt SHALL increment by 1.
REQ-013 If sync2 differs from deb and cnt == DEBOUNCE_CYCLES-1, deb SHALL take sync2 and cnt SHALL clear; cnt never wraps.
REQ-014 Any sample matching deb during a count SHALL restart the count from 0, so glitches shorter than DEBOUNCE_CYCLES samples are ignored.
REQ-015 An arbitration FSM SHALL have states IDLE, HELD0, HELD1 and CHORD (reset IDLE) and read deb0/deb1 as levels.
REQ-016 In IDLE: deb0=1 and deb1=0 -> HELD0 with b0 pulse; deb1=1 and deb0=0 -> HELD1 with b1 pulse; both 1 in the same cycle -> CHORD with chord_err pulse and no b0/b1.
REQ-017 In HELD0: deb1=1 -> CHORD with chord_err pulse; else deb0=0 -> IDLE; else stay. HELD1 SHALL behave symmetrically.
REQ-018 In CHORD: no pulses; -> IDLE only when deb0=0 and deb1=0.
REQ-019 b0, b1 and chord_err SHALL each be high for exactly one cycle per transition and never high together.
REQ-020 Latency: raw held high from sampling edge 0 -> deb=1 at edge DEBOUNCE_CYCLES+1 -> pulse registered at edge DEBOUNCE_CYCLES+2 (edge 18 at default) and deasserted at the following edge.
REQ-021 A release SHALL produce no pulse; a new press is accepted only after the FSM returns to IDLE.

Reset
REQ-022 With rst=1 at a posedge, sync flops, deb, cnt, b0, b1 and chord_err SHALL be 0 and the FSM SHALL be IDLE after that edge, regardless of in-progress counts.
REQ-023 After rst deasserts, a button still held SHALL be treated as a fresh press, with full REQ-020 latency counted from the first post-reset sampling edge.

Verification
REQ-024 Clean press: btn0_raw high for 40 cycles, then low -> single b0 pulse at edge 18; no b1, no chord_err; no pulse on release.
REQ-025 Bounce: btn0_raw toggles every 3 cycles for 30 cycles, then stays high -> exactly one b0 pulse, 18 edges after the final transition.
REQ-026 Glitch: btn1_raw high for 10 cycles only -> no b1 pulse; cnt returns to 0.
REQ-027 Chord: btn0 pressed, btn1 pressed 5 cycles later, both held -> b0 pulse, then one chord_err pulse, no b1; both released, then btn1 pressed -> one b1 pulse.
REQ-028 Simultaneous: both raw inputs rise on the same edge -> one chord_err pulse at edge 18; no b0/b1.
REQ-029 Reset mid-count: rst pulsed at edge 10 of a btn0 press, btn0 held -> outputs 0 during reset; b0 pulse 18 edges after the first post-reset sample.

Source files
------------

// File: rtl/button_conditioner.sv
// Two-button front end for the lock: synchronizes and debounces both raw
// buttons, then turns stable levels into one-cycle press / chord pulses.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn0_raw,
    input  logic btn1_raw,
    output logic b0,
    output logic b1,
    output logic chord_err
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD0 = 2'd1,
        HELD1 = 2'd2,
        CHORD = 2'd3
    } state_t;

    // Bit 0 of each vector belongs to button 0, bit 1 to button 1.
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       deb_q;
    logic [1:0]       deb_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    state_t state_q;
    state_t state_d;
    logic   b0_q;
    logic   b0_d;
    logic   b1_q;
    logic   b1_d;
    logic   chord_q;
    logic   chord_d;

    // Stage: synchronizer and debounce registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            sync1_q  <= {btn1_raw, btn0_raw};
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
        end
    end

    // A level is accepted only after DEBOUNCE_CYCLES differing samples in a row;
    // any matching sample (or the acceptance itself) restarts the count.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Stage: arbitration state and registered pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            b0_q    <= 1'b0;
            b1_q    <= 1'b0;
            chord_q <= 1'b0;
        end else begin
            state_q <= state_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            chord_q <= chord_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (deb_q[0] && deb_q[1]) begin
                    state_d = CHORD;
                end else if (deb_q[0]) begin
                    state_d = HELD0;
                end else if (deb_q[1]) begin
                    state_d = HELD1;
                end
            end
            HELD0: begin
                if (deb_q[1]) begin
                    state_d = CHORD;
                end else if (!deb_q[0]) begin
                    state_d = IDLE;
                end
            end
            HELD1: begin
                if (deb_q[0]) begin
                    state_d = CHORD;
                end else if (!deb_q[1]) begin
                    state_d = IDLE;
                end
            end
            CHORD: begin
                if (!deb_q[0] && !deb_q[1]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pulses fire only on entry into a holding state, so releases stay silent.
    always_comb begin
        b0_d    = (state_q == IDLE) && (state_d == HELD0);
        b1_d    = (state_q == IDLE) && (state_d == HELD1);
        chord_d = (state_q != CHORD) && (state_d == CHORD);
    end

    assign b0        = b0_q;
    assign b1        = b1_q;
    assign chord_err = chord_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bouncy input,
// checked cycle by cycle against a sample-window reference model.
module tb_button_conditioner;

    localparam int N    = 16;
    localparam int LAT  = N + 2;
    localparam int M_IDLE  = 0;
    localparam int M_HELD0 = 1;
    localparam int M_HELD1 = 2;
    localparam int M_CHORD = 3;

    logic clk = 1'b0;
    logic rst;
    logic btn0_raw;
    logic btn1_raw;
    logic b0;
    logic b1;
    logic chord_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit pipe0[$];
    bit pipe1[$];
    bit win0[$];
    bit win1[$];
    bit mdeb0;
    bit mdeb1;
    int mode;
    logic e_b0;
    logic e_b1;
    logic e_ce;

    button_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn0_raw  (btn0_raw),
        .btn1_raw  (btn1_raw),
        .b0        (b0),
        .b1        (b1),
        .chord_err (chord_err)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, advance the model over the edge, settle 1 time unit.
    task automatic step(input bit r0, input bit r1, input bit rs);
        bit s0;
        bit s1;
        bit all0;
        bit all1;
        btn0_raw = r0;
        btn1_raw = r1;
        rst      = rs;
        @(posedge clk);
        if (rs) begin
            pipe0 = {1'b0, 1'b0};
            pipe1 = {1'b0, 1'b0};
            win0.delete();
            win1.delete();
            mdeb0 = 0;
            mdeb1 = 0;
            mode  = M_IDLE;
            e_b0  = 0;
            e_b1  = 0;
            e_ce  = 0;
        end else begin
            e_b0 = 0;
            e_b1 = 0;
            e_ce = 0;
            if (mode == M_IDLE) begin
                if (mdeb0 && mdeb1) begin mode = M_CHORD; e_ce = 1; end
                else if (mdeb0)     begin mode = M_HELD0; e_b0 = 1; end
                else if (mdeb1)     begin mode = M_HELD1; e_b1 = 1; end
            end else if (mode == M_HELD0) begin
                if (mdeb1)       begin mode = M_CHORD; e_ce = 1; end
                else if (!mdeb0) mode = M_IDLE;
            end else if (mode == M_HELD1) begin
                if (mdeb0)       begin mode = M_CHORD; e_ce = 1; end
                else if (!mdeb1) mode = M_IDLE;
            end else begin
                if (!mdeb0 && !mdeb1) mode = M_IDLE;
            end
            // A level is taken once the last N synchronized samples all disagree with it.
            s0 = pipe0.pop_front();
            s1 = pipe1.pop_front();
            pipe0.push_back(r0);
            pipe1.push_back(r1);
            win0.push_back(s0);
            win1.push_back(s1);
            if (win0.size() > N) void'(win0.pop_front());
            if (win1.size() > N) void'(win1.pop_front());
            all0 = (win0.size() == N);
            all1 = (win1.size() == N);
            foreach (win0[k]) if (win0[k] == mdeb0) all0 = 0;
            foreach (win1[k]) if (win1[k] == mdeb1) all1 = 0;
            if (all0) mdeb0 = s0;
            if (all1) mdeb1 = s1;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1), 1'b1);
            n_cmp++;
            if ({b0, b1, chord_err} !== 3'b000) begin
                n_bad++;
                $display("FAIL reset cyc %0d: got b0/b1/ce=%b%b%b want 000", i, b0, b1, chord_err);
            end
        end
    endtask

    task automatic test_clean_press();
        int nb0 = 0, nb1 = 0, nce = 0, e0 = -1;
        for (int i = 0; i < 100; i++) begin
            step(i < 40, 1'b0, 1'b0);
            n_cmp++;
            if ({b0, b1, chord_err} !== {e_b0, e_b1, e_ce}) begin
                n_bad++;
                $display("FAIL clean_press cyc %0d: got %b%b%b want %b%b%b", i, b0, b1, chord_err, e_b0, e_b1, e_ce);
            end
            if (b0) begin nb0++; e0 = i; end
            if (b1) nb1++;
            if (chord_err) nce++;
        end
        n_cmp++;
        if (nb0 != 1 || e0 != LAT || nb1 != 0 || nce != 0) begin
            n_bad++;
            $display("FAIL clean_press_pulse: got b0 count %0d at edge %0d, b1 %0d, ce %0d; want 1 at %0d, 0, 0", nb0, e0, nb1, nce, LAT);
        end
    endtask

    task automatic test_bounce();
        int nb0 = 0, e0 = -1;
        bit r;
        for (int i = 0; i < 120; i++) begin
            if (i < 30) r = ((i / 3) % 2) == 0;
            else        r = (i < 80);
            step(r, 1'b0, 1'b0);
            n_cmp++;
            if ({b0, b1, chord_err} !== {e_b0, e_b1, e_ce}) begin
                n_bad++;
                $display("FAIL bounce cyc %0d: got %b%b%b want %b%b%b", i, b0, b1, chord_err, e_b0, e_b1, e_ce);
            end
            if (b0) begin nb0++; e0 = i; end
        end
        n_cmp++;
        if (nb0 != 1 || e0 != 30 + LAT) begin
            n_bad++;
            $display("FAIL bounce_pulse: got %0d pulses at edge %0d, want 1 at %0d", nb0, e0, 30 + LAT);
        end
    endtask

    task automatic test_glitch();
        int nb1 = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b0, i < 10, 1'b0);
            n_cmp++;
            if ({b0, b1, chord_err} !== {e_b0, e_b1, e_ce}) begin
                n_bad++;
                $display("FAIL glitch cyc %0d: got %b%b%b want %b%b%b", i, b0, b1, chord_err, e_b0, e_b1, e_ce);
            end
            if (b1) nb1++;
        end
        // A 15-cycle pulse is one sample short of acceptance; it must also vanish.
        for (int i = 0; i < 50; i++) begin
            step(1'b0, i < N - 1, 1'b0);
            if (b1) nb1++;
        end
        n_cmp++;
        if (nb1 != 0) begin
            n_bad++;
            $display("FAIL glitch_pulse: got %0d b1 pulses, want 0", nb1);
        end
    endtask

    task automatic test_chord();
        int nb0 = 0, nb1 = 0, nce = 0, e0 = -1, e1 = -1, ec = -1;
        for (int i = 0; i < 200; i++) begin
            step(i < 60, (i >= 5 && i < 60) || (i >= 100 && i < 150), 1'b0);
            n_cmp++;
            if ({b0, b1, chord_err} !== {e_b0, e_b1, e_ce}) begin
                n_bad++;
                $display("FAIL chord cyc %0d: got %b%b%b want %b%b%b", i, b0, b1, chord_err, e_b0, e_b1, e_ce);
            end
            if (b0) begin nb0++; e0 = i; end
            if (b1) begin nb1++; e1 = i; end
            if (chord_err) begin nce++; ec = i; end
        end
        n_cmp++;
        if (nb0 != 1 || e0 != LAT || nce != 1 || ec != 5 + LAT || nb1 != 1 || e1 != 100 + LAT) begin
            n_bad++;
            $display("FAIL chord_seq: got b0 %0d@%0d ce %0d@%0d b1 %0d@%0d, want 1@%0d 1@%0d 1@%0d",
                     nb0, e0, nce, ec, nb1, e1, LAT, 5 + LAT, 100 + LAT);
        end
    endtask

    task automatic test_simultaneous();
        int nb = 0, nce = 0, ec = -1;
        for (int i = 0; i < 80; i++) begin
            step(i < 40, i < 40, 1'b0);
            n_cmp++;
            if ({b0, b1, chord_err} !== {e_b0, e_b1, e_ce}) begin
                n_bad++;
                $display("FAIL simultaneous cyc %0d: got %b%b%b want %b%b%b", i, b0, b1, chord_err, e_b0, e_b1, e_ce);
            end
            if (b0 || b1) nb++;
            if (chord_err) begin nce++; ec = i; end
        end
        n_cmp++;
        if (nb != 0 || nce != 1 || ec != LAT) begin
            n_bad++;
            $display("FAIL simultaneous_pulse: got b0/b1 %0d, ce %0d at %0d; want 0, 1 at %0d", nb, nce, ec, LAT);
        end
    endtask

    task automatic test_reset_mid_count();
        int nb0 = 0, e0 = -1;
        for (int i = 0; i < 100; i++) begin
            step(i < 60, 1'b0, i == 10);
            n_cmp++;
            if ({b0, b1, chord_err} !== {e_b0, e_b1, e_ce}) begin
                n_bad++;
                $display("FAIL reset_mid cyc %0d: got %b%b%b want %b%b%b", i, b0, b1, chord_err, e_b0, e_b1, e_ce);
            end
            if (b0) begin nb0++; e0 = i; end
        end
        n_cmp++;
        if (nb0 != 1 || e0 != 11 + LAT) begin
            n_bad++;
            $display("FAIL reset_mid_pulse: got %0d at edge %0d, want 1 at %0d", nb0, e0, 11 + LAT);
        end
    endtask

    task automatic test_random();
        bit r0 = 0, r1 = 0;
        int h0 = 0, h1 = 0;
        for (int i = 0; i < 4000; i++) begin
            if (h0 == 0) begin
                r0 = $urandom_range(0, 1);
                h0 = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : $urandom_range(10, 45);
            end
            if (h1 == 0) begin
                r1 = $urandom_range(0, 1);
                h1 = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : $urandom_range(10, 45);
            end
            h0--;
            h1--;
            step(r0, r1, $urandom_range(0, 299) == 0);
            n_cmp++;
            if ({b0, b1, chord_err} !== {e_b0, e_b1, e_ce}) begin
                n_bad++;
                $display("FAIL random cyc %0d: got %b%b%b want %b%b%b", i, b0, b1, chord_err, e_b0, e_b1, e_ce);
            end
            n_cmp++;
            if ($countones({b0, b1, chord_err}) > 1) begin
                n_bad++;
                $display("FAIL random_exclusive cyc %0d: got %b%b%b, want at most one high", i, b0, b1, chord_err);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        btn0_raw = 1'b0;
        btn1_raw = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_chord();
        test_simultaneous();
        test_reset_mid_count();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
